// File: rtl/node_ni_v2.sv
// node_ni_v2 - local network interface for a router node.
//
// Generates rate-controlled single-flit traffic into the router local input
// and sinks/checks flits arriving from the router local output.
//
// Flit layout: {hdr[HDR_SZ], payload[PL_SZ], dest[ADDR_SZ]},
// where payload = {src_id[ADDR_SZ], seq[PL_SZ-ADDR_SZ]}.
//
// Ports
//   clk        node clock
//   reset      asynchronous, active-low reset
//   id         own node address (static after reset)
//   en         injection enable
//   item_out   flit to router local input
//   req        item_out valid
//   ch_busy    router local input cannot accept
//   item_in    flit from router local output
//   valid      item_in valid
//   busy       RX queue full
//   error      sticky check failure
//   led        toggles every 2**LED_SHIFT good received flits
//   tx_count   flits handed to router (wraps)
//   rx_count   flits popped from RX queue (wraps)
//   drop_count injections dropped on a full TX queue (saturates)
//
// Optional feature: define SEQ_CHECK_EN to add a per-source expected-sequence
// table to the receive check.
//
// State table
//   OS_EMPTY  | output register holds nothing, req=0
//   OS_VALID  | output register holds a flit, req=1 until transferred
//   CHK_OK    | no check failure seen since reset
//   CHK_ERR   | a check failure was seen, error=1 until reset

module node_ni_v2 #(
  parameter int ADDR_SZ      = 4,
  parameter int HDR_SZ       = 2,
  parameter int HDR_VAL      = 1,
  parameter int PL_SZ        = 16,
  parameter int INJ_PERIOD   = 8,
  parameter int TXQ_DEPTH    = 4,
  parameter int RXQ_DEPTH    = 4,
  parameter int DRAIN_PERIOD = 1,
  parameter int LED_SHIFT    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_SZ-1:0]                id,
  input  logic                              en,
  output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   item_out,
  output logic                              req,
  input  logic                              ch_busy,
  input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   item_in,
  input  logic                              valid,
  output logic                              busy,
  output logic                              error,
  output logic                              led,
  output logic [19:0]                       tx_count,
  output logic [19:0]                       rx_count,
  output logic [15:0]                       drop_count
);

  localparam int W     = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int SEQ_W = PL_SZ - ADDR_SZ;
  localparam int PW    = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
  localparam int DW    = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam int TAW   = $clog2(TXQ_DEPTH);
  localparam int RAW   = $clog2(RXQ_DEPTH);

  localparam logic [PW-1:0]      PCNT_LAST = PW'(INJ_PERIOD - 1);
  localparam logic [PW-1:0]      PCNT_ONE  = PW'(1);
  localparam logic [DW-1:0]      DCNT_LAST = DW'(DRAIN_PERIOD - 1);
  localparam logic [DW-1:0]      DCNT_ONE  = DW'(1);
  localparam logic [TAW:0]       TXQ_FULL  = (TAW+1)'(TXQ_DEPTH);
  localparam logic [TAW:0]       TXC_ONE   = (TAW+1)'(1);
  localparam logic [TAW-1:0]     TXP_ONE   = TAW'(1);
  localparam logic [RAW:0]       RXQ_FULL  = (RAW+1)'(RXQ_DEPTH);
  localparam logic [RAW:0]       RXC_ONE   = (RAW+1)'(1);
  localparam logic [RAW-1:0]     RXP_ONE   = RAW'(1);
  localparam logic [HDR_SZ-1:0]  HDR_CODE  = HDR_SZ'(HDR_VAL);
  localparam logic [ADDR_SZ-1:0] ADDR_ONE  = ADDR_SZ'(1);
  localparam logic [SEQ_W-1:0]   SEQ_ONE   = SEQ_W'(1);

  // ---------------------------------------------------------------------------
  // Injection timer, LFSR destination and sequence number
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      pcnt;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [SEQ_W-1:0]   seq;
  logic               tick;
  logic [ADDR_SZ-1:0] dest_raw;
  logic [ADDR_SZ-1:0] dest_sel;
  logic [W-1:0]       new_flit;

  assign tick      = en && (pcnt == PCNT_LAST);
  // Galois-free right-shift form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign dest_raw  = lfsr_next[ADDR_SZ-1:0];
  // never address ourselves
  assign dest_sel  = (dest_raw == id) ? (dest_raw ^ ADDR_ONE) : dest_raw;
  assign new_flit  = {HDR_CODE, id, seq, dest_sel};

  // ---------------------------------------------------------------------------
  // TX queue + output register
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {OS_EMPTY, OS_VALID} os_state_t;

  os_state_t      os_state;
  logic [W-1:0]   txq [TXQ_DEPTH];
  logic [TAW-1:0] tx_wr;
  logic [TAW-1:0] tx_rd;
  logic [TAW:0]   tx_cnt;
  logic           xfer;
  logic           out_free;
  logic           txq_pop;
  logic           txq_push;
  logic           push_ok;
  logic           bypass;
  logic           drop;

  assign xfer     = req && !ch_busy;
  assign out_free = (os_state == OS_EMPTY) || xfer;
  assign txq_pop  = xfer && (tx_cnt != '0);
  // a pop in the same cycle frees a slot, so a full queue can still accept
  assign push_ok  = tick && ((tx_cnt != TXQ_FULL) || txq_pop);
  // output register empty (or emptying) with nothing queued: load it directly
  // so req rises the cycle after the tick
  assign bypass   = push_ok && out_free && (tx_cnt == '0);
  assign txq_push = push_ok && !bypass;
  assign drop     = tick && !push_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt       <= '0;
      lfsr       <= 16'hACE1;
      seq        <= '0;
      drop_count <= '0;
    end else begin
      if (en) begin
        pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + PCNT_ONE;
      end
      if (tick) begin
        lfsr <= lfsr_next;
      end
      if (push_ok) begin
        seq <= seq + SEQ_ONE;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (txq_push) begin
      txq[tx_wr] <= new_flit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (txq_push) tx_wr <= tx_wr + TXP_ONE;
      if (txq_pop)  tx_rd <= tx_rd + TXP_ONE;
      case ({txq_push, txq_pop})
        2'b10:   tx_cnt <= tx_cnt + TXC_ONE;
        2'b01:   tx_cnt <= tx_cnt - TXC_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      os_state <= OS_EMPTY;
      req      <= 1'b0;
      item_out <= '0;
      tx_count <= '0;
    end else begin
      case (os_state)
        OS_EMPTY: begin
          if (bypass) begin
            item_out <= new_flit;
            req      <= 1'b1;
            os_state <= OS_VALID;
          end
        end
        OS_VALID: begin
          if (xfer) begin
            tx_count <= tx_count + 20'd1;
            if (txq_pop) begin
              item_out <= txq[tx_rd];
            end else if (bypass) begin
              item_out <= new_flit;
            end else begin
              req      <= 1'b0;
              os_state <= OS_EMPTY;
            end
          end
        end
        default: begin
          req      <= 1'b0;
          os_state <= OS_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX queue and drain timer
  // ---------------------------------------------------------------------------
  logic [W-1:0]   rxq [RXQ_DEPTH];
  logic [RAW-1:0] rx_wr;
  logic [RAW-1:0] rx_rd;
  logic [RAW:0]   rx_cnt;
  logic [DW-1:0]  dcnt;
  logic           accept;
  logic           pop;
  logic [W-1:0]   rx_head;

  assign busy    = (rx_cnt == RXQ_FULL);
  assign accept  = valid && !busy;
  assign pop     = (rx_cnt != '0) && (dcnt == DCNT_LAST);
  assign rx_head = rxq[rx_rd];

  always_ff @(posedge clk) begin
    if (accept) begin
      rxq[rx_wr] <= item_in;
    end
  end

  // drain timer only runs while something is queued, so the first pop comes
  // DRAIN_PERIOD cycles after the queue turns non-empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      dcnt   <= '0;
    end else begin
      if (accept) rx_wr <= rx_wr + RXP_ONE;
      if (pop)    rx_rd <= rx_rd + RXP_ONE;
      case ({accept, pop})
        2'b10:   rx_cnt <= rx_cnt + RXC_ONE;
        2'b01:   rx_cnt <= rx_cnt - RXC_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
      if ((rx_cnt == '0) || (dcnt == DCNT_LAST)) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DCNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive check
  // ---------------------------------------------------------------------------
  logic [HDR_SZ-1:0]  rx_hdr;
  logic [ADDR_SZ-1:0] rx_dest;
  logic               seq_bad;
  logic               flit_bad;

  assign rx_hdr  = rx_head[W-1 -: HDR_SZ];
  assign rx_dest = rx_head[ADDR_SZ-1:0];

`ifdef SEQ_CHECK_EN
  localparam int NUM_NODES = 2 ** ADDR_SZ;

  logic [ADDR_SZ-1:0]   rx_src;
  logic [SEQ_W-1:0]     rx_seq;
  logic [NUM_NODES-1:0] seen;
  logic [SEQ_W-1:0]     exp_seq [NUM_NODES];

  assign rx_src  = rx_head[ADDR_SZ+PL_SZ-1 -: ADDR_SZ];
  assign rx_seq  = rx_head[ADDR_SZ +: SEQ_W];
  // first flit from a source only initialises its entry
  assign seq_bad = seen[rx_src] && (rx_seq != exp_seq[rx_src]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        exp_seq[i] <= '0;
      end
    end else if (pop) begin
      seen[rx_src]    <= 1'b1;
      exp_seq[rx_src] <= rx_seq + SEQ_ONE;
    end
  end
`else
  logic unused_payload;

  assign seq_bad        = 1'b0;
  assign unused_payload = ^rx_head[ADDR_SZ +: PL_SZ];
`endif

  assign flit_bad = (rx_hdr != HDR_CODE) || (rx_dest != id) || seq_bad;

  typedef enum logic [0:0] {CHK_OK, CHK_ERR} chk_state_t;

  chk_state_t  chk_state;
  logic [19:0] rx_count_nxt;

  assign rx_count_nxt = rx_count + 20'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_state <= CHK_OK;
      error     <= 1'b0;
      led       <= 1'b0;
      rx_count  <= '0;
    end else if (pop) begin
      rx_count <= rx_count_nxt;
      case (chk_state)
        CHK_OK: begin
          if (flit_bad) begin
            chk_state <= CHK_ERR;
            error     <= 1'b1;
          end
        end
        CHK_ERR: begin
          error <= 1'b1;
        end
        default: begin
          chk_state <= CHK_ERR;
          error     <= 1'b1;
        end
      endcase
      if (!flit_bad && (rx_count_nxt[LED_SHIFT-1:0] == '0)) begin
        led <= ~led;
      end
    end
  end

endmodule
